// File: rtl/div_seq_32.sv
// div_seq_32: 32-step restoring sequential divider with sign correction and
// divide-by-zero / signed-overflow flagging.
module div_seq_32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] S,
  input  logic [31:0] T,
  output logic        busy,
  output logic        done,
  output logic [31:0] Y_lo,
  output logic [31:0] Y_hi,
  output logic        C,
  output logic        V,
  output logic        N,
  output logic        Z
);
  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;
  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_rem, r_quo, r_den;
  logic        r_qs, r_rs, r_dz, r_ovf;
  logic        w_acc, w_tz;
  logic [31:0] w_sa, w_ta, w_ylo, w_yhi;
  logic [32:0] w_sh, w_diff;
  assign w_acc  = (r_state == IDLE) && start;
  assign w_tz   = (T == 32'd0);
  assign w_sa   = (sgn && S[31]) ? -S : S;
  assign w_ta   = (sgn && T[31]) ? -T : T;
  assign w_sh   = {r_rem, r_quo[31]};
  assign w_diff = w_sh - {1'b0, r_den};
  // On divide-by-zero r_quo holds the raw dividend so it can be returned as remainder
  assign w_ylo  = r_dz ? 32'hFFFFFFFF : (r_qs ? -r_quo : r_quo);
  assign w_yhi  = r_dz ? r_quo : (r_rs ? -r_rem : r_rem);
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next = r_state;
    busy   = (r_state != IDLE);
    w_next = (r_state == IDLE) ? (start ? (w_tz ? FIX : DIV) : IDLE) :
             (r_state == DIV)  ? ((r_cnt == 5'd31) ? FIX : DIV) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_den <= '0;
      r_qs  <= 1'b0;
      r_rs  <= 1'b0;
      r_dz  <= 1'b0;
      r_ovf <= 1'b0;
      done  <= 1'b0;
      Y_lo  <= '0;
      Y_hi  <= '0;
      C     <= 1'b0;
      V     <= 1'b0;
      N     <= 1'b0;
      Z     <= 1'b0;
    end else begin
      done <= (r_state == FIX);
      if (w_acc) begin
        r_dz  <= w_tz;
        r_qs  <= sgn & (S[31] ^ T[31]);
        r_rs  <= sgn & S[31];
        r_ovf <= sgn && (S == 32'h80000000) && (T == 32'hFFFFFFFF);
        r_rem <= '0;
        r_cnt <= '0;
        r_quo <= w_tz ? S : w_sa;
        r_den <= w_ta;
      end
      if (r_state == DIV) begin
        r_rem <= w_diff[32] ? w_sh[31:0] : w_diff[31:0];
        r_quo <= {r_quo[30:0], ~w_diff[32]};
        r_cnt <= r_cnt + 5'd1;
      end
      if (r_state == FIX) begin
        Y_lo <= w_ylo;
        Y_hi <= w_yhi;
        C    <= 1'b0;
        V    <= r_dz | r_ovf;
        N    <= w_ylo[31];
        Z    <= (w_ylo == 32'd0);
      end
    end
  end
endmodule

// File: tb/tb_div_seq_32.sv
// tb_div_seq_32: directed vectors; expected results queued at issue and
// checked by an independent monitor whenever done pulses.
module tb_div_seq_32;
  logic        clk = 0, reset = 1, start = 0, sgn = 0;
  logic [31:0] S = 0, T = 0;
  logic        busy, done, C, V, N, Z;
  logic [31:0] Y_lo, Y_hi;
  int          vecs = 0, errs = 0;
  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        v, n, z;
  } exp_t;
  exp_t q[$];
  div_seq_32 dut (
    .clk(clk), .reset(reset), .start(start), .sgn(sgn), .S(S), .T(T),
    .busy(busy), .done(done), .Y_lo(Y_lo), .Y_hi(Y_hi),
    .C(C), .V(V), .N(N), .Z(Z)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (done) begin
      vecs++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_done: got lo=%h hi=%h with no pending request", Y_lo, Y_hi);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({Y_lo, Y_hi, C, V, N, Z} !== {e.lo, e.hi, 1'b0, e.v, e.n, e.z}) begin
          errs++;
          $display("FAIL result: got lo=%h hi=%h C=%b V=%b N=%b Z=%b, want lo=%h hi=%h C=0 V=%b N=%b Z=%b",
                   Y_lo, Y_hi, C, V, N, Z, e.lo, e.hi, e.v, e.n, e.z);
        end
      end
    end
  end
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask
  // Issue one divide; poke_at injects an ignored start, rst_at aborts with reset.
  task automatic run(input logic s_g, input logic [31:0] s_v, input logic [31:0] t_v,
                     input logic [31:0] lo, input logic [31:0] hi, input logic v,
                     input logic n, input logic z, input int lat, input int poke_at,
                     input int rst_at);
    int k = 1, nb = 0;
    sgn = s_g; S = s_v; T = t_v; start = 1;
    if (rst_at == 0) q.push_back('{lo, hi, v, n, z});
    @(posedge clk); #1;
    start = 0; sgn = ~s_g; S = 32'h0BAD_F00D; T = 32'h3;
    while (!done && k < 100) begin
      if (busy) nb++;
      if (k == poke_at) begin sgn = 0; S = 7; T = 3; start = 1; end
      else start = 0;
      if (k == rst_at) begin
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);
        check("reset_y", {Y_lo, Y_hi}, 64'd0);
        check("reset_flags", {60'd0, C, V, N, Z}, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        return;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 0;
    check("latency", 64'(k), 64'(lat));
    check("busy_cycles", 64'(nb), 64'(lat - 1));
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {Y_lo[15:0], Y_hi[15:0], 26'd0, busy, done, C, V, N, Z}, 64'd0);
    reset = 0;
    run(1, 100, 7, 14, 2, 0, 0, 0, 34, 0, 0);
    run(1, 32'hFFFFFFF9, 2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 1, 0, 34, 0, 0);
    run(0, 32'hFFFFFFFF, 2, 32'h7FFFFFFF, 1, 0, 0, 0, 34, 0, 0);
    run(0, 32'h12345678, 0, 32'hFFFFFFFF, 32'h12345678, 1, 1, 0, 2, 0, 0);
    run(1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1, 1, 0, 34, 0, 0);
    run(1, 5, 9, 0, 5, 0, 0, 1, 34, 0, 0);
    run(1, 100, 32'hFFFFFFF9, 32'hFFFFFFF2, 2, 0, 1, 0, 34, 0, 0);
    run(1, 32'h0000ABCD, 0, 32'hFFFFFFFF, 32'h0000ABCD, 1, 1, 0, 2, 0, 0);
    run(1, 32'hFFFF0000, 0, 32'hFFFFFFFF, 32'hFFFF0000, 1, 1, 0, 2, 0, 0);
    run(0, 1000, 10, 100, 0, 0, 0, 0, 34, 10, 0);
    repeat (40) @(posedge clk);
    #1;
    run(0, 32'hDEADBEEF, 13, 0, 0, 0, 0, 0, 0, 0, 20);
    run(1, 32'hFFFFFF9C, 7, 32'hFFFFFFF2, 32'hFFFFFFFE, 0, 1, 0, 34, 0, 0);
    run(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 34, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
